cordic_range_reduce: RTL
========================

// Module: cordic_range_reduce
// PURPOSE
//  Argument range-reduction stage feeding the unrolled CORDIC cosine unit.
//  - Takes a wide signed fixed-point angle in radians (20 fraction bits).
//  - Reduces it to r in [-pi/2, +pi/2], the 22-bit format the CORDIC accepts.
//  - Also outputs a negate flag, so that cos(angle) = negate ? -cos(r) : cos(r).
//  - Iterative restoring modulo-2pi, then a quadrant fold; valid/ready on both sides.
// PARAMETERS
//  ANGLE_W  32  input width, signed Q(ANGLE_W-21).20; must satisfy 24 <= ANGLE_W <= 40
//  K        ANGLE_W-22  modulo iterations (localparam, not overridable)
// PORTS
//  clk          in   1        clock, all logic on posedge
//  reset        in   1        synchronous, active-high
//  in_valid     in   1        in_angle valid
//  in_ready     out  1        high only in IDLE
//  in_angle     in   ANGLE_W  signed angle, rad * 2^20
//  out_valid    out  1        result valid; drives the CORDIC start input
//  out_ready    in   1        consumer accepts the result
//  out_angle    out  22       signed Q1.20 reduced angle r, |r| <= PI_2
//  out_negate   out  1        1 -> consumer must negate its cos result
// BEHAVIOUR
//  Constants (x2^20, rounded): PI=3294199, TWO_PI=6588398, PI_2=1647099.
//  Reset: state=IDLE, in_ready=1, out_valid=0, out_angle=0, out_negate=0.
//  Reset mid-operation aborts: the in-flight angle is discarded and no out_valid is produced.
//  FSM IDLE -> REDUCE -> FOLD -> DONE -> IDLE.
//  IDLE: on in_valid & in_ready:
//   - latch sign s = in_angle[MSB];
//   - latch mag = |in_angle| in an ANGLE_W+2 bit unsigned register (-2^(ANGLE_W-1) is handled exactly);
//   - set k=K-1 and go to REDUCE.
//  REDUCE, one step per cycle for k=K-1..0:
//   - if mag >= (TWO_PI<<k) then mag -= TWO_PI<<k;
//   - after the k=0 step go to FOLD.
//  FOLD, one cycle, combinational on mag, registered into out_*:
//   1. rem = s ? -mag : mag  (rem is in (-2pi, 2pi)).
//   2. if rem > PI then rem -= TWO_PI; if rem < -PI then rem += TWO_PI.
//   3. if rem > PI_2: out_angle = PI-rem, out_negate=1.
//      else if rem < -PI_2: out_angle = -PI-rem, out_negate=1.
//      else: out_angle = rem, out_negate=0.
//   - rem == PI is treated as > PI_2, giving (0, negate=1).
//   - rem == PI_2 is not folded.
//  DONE: out_valid=1 and out_* held stable until out_valid & out_ready.
//   - That cycle returns the FSM to IDLE; in_ready rises the following cycle.
//   - There is no same-cycle accept of a new input.
//  Latency: out_valid is high K+2 posedges after the accepting edge (12 for ANGLE_W=32).
//  Throughput: one angle per K+3 cycles with out_ready held high.
//  in_angle is sampled only at the accepting edge; later input changes are ignored.
//  All arithmetic is two's complement, at least ANGLE_W+2 bits internally.
//  out_angle is always in [-PI_2, PI_2], so no overflow is possible.
// CONFIGURATION
//  CORDIC_RRED_BYPASS_EN defined:
//   - in IDLE, if -PI_2 <= in_angle <= PI_2, skip REDUCE: FSM goes IDLE -> FOLD with mag = |in_angle|;
//   - latency becomes 2 for those angles;
//   - results are identical to the non-bypass path.
//  Not defined: every angle takes the K-step REDUCE path; latency is fixed at K+2.
// TESTING
//  - Reset: hold reset 2 cycles -> out_valid=0, in_ready=1, out_angle=0, out_negate=0.
//  - in_angle=0 -> out_angle=0, neg=0, exactly 12 cycles later (ANGLE_W=32, no bypass).
//  - in_angle=3294199 (pi) -> out_angle=0, neg=1.
//  - in_angle=7112686 (2pi+0.5) -> out_angle=524288, neg=0.
//  - in_angle=-2097152 (-2.0) -> out_angle=-1197047, neg=1.
//  - in_angle=-2^31 -> out_angle=334100, neg=0.
//  - out_ready held 0 for 5 cycles -> out_* stable and in_ready=0 throughout.
//  - reset asserted during REDUCE -> no out_valid; the next angle then completes correctly.
//  - With CORDIC_RRED_BYPASS_EN: in_angle=524288 -> out_valid 2 cycles after accept.
//  - With CORDIC_RRED_BYPASS_EN: in_angle=1647100 (just above PI_2) -> 12-cycle latency.
//  - Random 10k angles vs real-valued model -> |error| <= 1 LSB, plus the cos sign check.

Source files
------------

// File: rtl/cordic_range_reduce.sv
// Range reduction for the CORDIC cosine unit: restoring modulo-2pi on |angle|, then a
// quadrant fold into [-pi/2, pi/2] with a negate flag. Define CORDIC_RRED_BYPASS_EN to skip REDUCE for small angles.
module cordic_range_reduce #(
  parameter int ANGLE_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [ANGLE_W-1:0] in_angle,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [21:0]        out_angle,
  output logic                      out_negate
);
  localparam int K  = ANGLE_W - 22;
  localparam int W  = ANGLE_W + 2;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  localparam logic signed [W-1:0] PI_S     = W'(3294199);
  localparam logic signed [W-1:0] TWO_PI_S = W'(6588398);
  localparam logic signed [W-1:0] PI2_S    = W'(1647099);
  localparam logic        [W-1:0] TWO_PI_U = W'(6588398);

  typedef enum logic [1:0] {IDLE, REDUCE, FOLD, DONE} state_t;
  state_t state, state_nxt;

  logic                 s;
  logic [W-1:0]         mag;
  logic [KW-1:0]        k;
  logic signed [W-1:0]  in_ext, in_abs;
  logic [W-1:0]         sub;
  logic                 bypass;
  logic signed [W-1:0]  rem0, rem1, fold_angle;
  logic                 fold_neg;
  logic                 fold_unused;

  // Two extra bits keep |-2^(ANGLE_W-1)| exact and leave room for the signed fold.
  assign in_ext = {{2{in_angle[ANGLE_W-1]}}, in_angle};
  assign in_abs = in_angle[ANGLE_W-1] ? -in_ext : in_ext;
  assign sub    = TWO_PI_U << k;

`ifdef CORDIC_RRED_BYPASS_EN
  assign bypass = (in_ext >= -PI2_S) && (in_ext <= PI2_S);
`else
  assign bypass = 1'b0;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    rem0 = s ? -$signed(mag) : $signed(mag);
    rem1 = rem0;
    if (rem0 > PI_S)       rem1 = rem0 - TWO_PI_S;
    else if (rem0 < -PI_S) rem1 = rem0 + TWO_PI_S;
    fold_angle = rem1;
    fold_neg   = 1'b0;
    if (rem1 > PI2_S) begin
      fold_angle = PI_S - rem1;
      fold_neg   = 1'b1;
    end else if (rem1 < -PI2_S) begin
      fold_angle = -PI_S - rem1;
      fold_neg   = 1'b1;
    end
  end

  // The fold result always fits in 22 bits; the upper bits are sign copies.
  assign fold_unused = ^fold_angle[W-1:22];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = bypass ? FOLD : REDUCE;
      REDUCE:  if (k == '0) state_nxt = FOLD;
      FOLD:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s          <= 1'b0;
      mag        <= '0;
      k          <= '0;
      out_angle  <= '0;
      out_negate <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          s   <= in_angle[ANGLE_W-1];
          mag <= in_abs;
          k   <= KW'(K - 1);
        end
        REDUCE: begin
          if (mag >= sub) mag <= mag - sub;
          k <= k - 1'b1;
        end
        FOLD: begin
          out_angle  <= fold_angle[21:0];
          out_negate <= fold_neg;
        end
        default: ;
      endcase
    end
  end
endmodule
